fib_sequencer: RTL and testbench



---
 rtl/fib_sequencer.sv | 65 ++++++
 tb/tb_fib_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fib_sequencer.sv
// fib_sequencer: iterative Fibonacci engine with start/done handshake and sticky overflow
module fib_sequencer #(
  parameter int W  = 16,
  parameter int NW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] n,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          overflow
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  logic [1:0]    state;
  logic [W-1:0]  a, b;
  logic [NW-1:0] cnt;
  logic          fa, fb;
  logic [W:0]    sum;
  assign sum = {1'b0, a} + {1'b0, b};
  // a holds F(k), b holds F(k+1); the result is taken from a so a carry into F(n+1) never reaches overflow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      cnt      <= '0;
      fa       <= 1'b0;
      fb       <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          state <= CALC;
          a     <= '0;
          b     <= {{(W-1){1'b0}}, 1'b1};
          fa    <= 1'b0;
          fb    <= 1'b0;
          cnt   <= n;
          busy  <= 1'b1;
        end
        CALC: if (cnt == '0) begin
          state    <= DONE;
          result   <= a;
          overflow <= fa;
          busy     <= 1'b0;
          done     <= 1'b1;
        end else begin
          a   <= b;
          fa  <= fb;
          b   <= sum[W-1:0];
          fb  <= fb | fa | sum[W];
          cnt <= cnt - 1'b1;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_fib_sequencer.sv
// tb_fib_sequencer: scoreboard bench for fib_sequencer with directed vectors
module tb_fib_sequencer;
  localparam int W = 16, NW = 5;
  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [NW-1:0] n = '0;
  logic          busy, done, overflow;
  logic [W-1:0]  result;
  int checks = 0, errors = 0, cyc = 0, busy_run = 0;
  logic prev_done = 1'b0;
  typedef struct {logic [W-1:0] res; logic ov; int n; int t;} exp_t;
  exp_t q[$];
  exp_t e;

  fib_sequencer #(.W(W), .NW(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n),
    .busy(busy), .done(done), .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;
  // cyc counts rising edges; read #1 after an edge it equals that edge's index
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at edge %0d", name, act, req, cyc);
    end
  endtask

  // done belongs to the cycle ending at edge T+n+2, so it is seen n+1 edges after the start edge T
  always @(negedge clk) begin
    if (!rst_n) busy_run = 0;
    else if (busy) busy_run++;
    if (prev_done) check("done_width", done, 0);
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done result %0d at edge %0d", result, cyc);
      end else begin
        e = q.pop_front();
        check($sformatf("result_n%0d", e.n), result, e.res);
        check($sformatf("overflow_n%0d", e.n), overflow, e.ov);
        check($sformatf("latency_n%0d", e.n), cyc - e.t, e.n + 1);
        check($sformatf("busy_cycles_n%0d", e.n), busy_run, e.n + 1);
        check($sformatf("busy_with_done_n%0d", e.n), busy, 0);
      end
      busy_run = 0;
    end
    prev_done = done;
  end

  task automatic go(input int nv, input logic [W-1:0] res, input logic ov, input bit push);
    @(negedge clk);
    start = 1'b1;
    n = NW'(nv);
    @(posedge clk);
    #1;
    if (push) q.push_back('{res, ov, nv, cyc});
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_done got %0d pending expected 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 200 && !done; i++) @(negedge clk);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout_wait_done got %0d expected 1", done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_overflow", overflow, 0);
    go(0, 16'd0, 1'b0, 1'b1);  wait_idle();
    go(1, 16'd1, 1'b0, 1'b1);  wait_idle();
    go(10, 16'd55, 1'b0, 1'b1); wait_idle();
    go(24, 16'd46368, 1'b0, 1'b1); wait_idle();
    go(10, 16'd55, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    n = 5'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    start = 1'b1;
    n = 5'd3;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("hold_idle_busy", busy, 0);
    check("hold_idle_result", result, 55);
    go(3, 16'd2, 1'b0, 1'b1);
    check("hold_calc_result", result, 55);
    wait_idle();
    go(25, 16'd9489, 1'b1, 1'b1); wait_idle();
    go(20, 16'd0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_result", result, 0);
    check("async_rst_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    go(5, 16'd5, 1'b0, 1'b1); wait_idle();
    repeat (30) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
